// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Single-issue front end for an external combinational ALU. An accepted
//   instruction reads its two operands from a small register file, presents
//   them to the ALU for one cycle, writes the ALU result back into the
//   register file and offers it on a valid/ready result port.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid, in_ready              instruction handshake
//   in_op, in_dst, in_srca, in_srcb ALU select code and register indices
//   wr_en, wr_addr, wr_data         direct register load, usable in any state
//   alu_a, alu_b, alu_sel           operands and select to the external ALU
//   alu_res                         combinational result from the external ALU
//   out_valid, out_ready            result handshake
//   out_data, out_dst, out_zero     result value, destination index, zero flag
module alu_issue_stage #(
  parameter int WIDTH = 6,
  parameter int NREG  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [1:0]       in_dst,
  input  logic [1:0]       in_srca,
  input  logic [1:0]       in_srcb,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_dst,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] rf [NREG];
  logic [1:0]       dst_p1;
  logic             accept_p0;
  logic             wb_p1;

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == '0);
  endfunction

  // in_ready is gated by rst_n so it reads low for the whole reset window,
  // not just after the first edge.
  assign in_ready  = (state == IDLE) && rst_n;
  assign accept_p0 = in_valid && in_ready;
  assign wb_p1     = (state == EXEC);
  assign out_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_p0) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage 0 -> 1: operand read and issue to the ALU ----
  // Operands are sampled from the register file as it stood before this
  // edge, so a same-edge load or writeback is not seen by the new issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      dst_p1  <= '0;
    end else if (accept_p0) begin
      alu_a   <= rf[in_srca];
      alu_b   <= rf[in_srcb];
      alu_sel <= in_op;
      dst_p1  <= in_dst;
    end
  end

  // ---- stage 1 -> 2: result capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_dst  <= '0;
      out_zero <= 1'b0;
    end else if (wb_p1) begin
      out_data <= alu_res;
      out_dst  <= dst_p1;
      out_zero <= is_zero(alu_res);
    end
  end

  // Register file. The writeback assignment comes last so that it wins a
  // same-edge collision with a direct load to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        rf[wr_addr] <= wr_data;
      end
      if (wb_p1) begin
        rf[dst_p1] <= alu_res;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  localparam int WIDTH = 6;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [1:0]       in_dst;
  logic [1:0]       in_srca;
  logic [1:0]       in_srcb;
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] alu_res;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_dst;
  logic             out_zero;

  int n_tests;
  int n_fail;

  alu_issue_stage #(.WIDTH(WIDTH), .NREG(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_dst   (in_dst),
    .in_srca  (in_srca),
    .in_srcb  (in_srcb),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_res  (alu_res),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_dst  (out_dst),
    .out_zero (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU stand-in: 0000 AND, 0001 OR, 0010 XOR, 0011 NOT A,
  // 0110 ADD, 1010 SUB, anything else yields zero.
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      4'b0000: alu_res = alu_a & alu_b;
      4'b0001: alu_res = alu_a | alu_b;
      4'b0010: alu_res = alu_a ^ alu_b;
      4'b0011: alu_res = ~alu_a;
      4'b0110: alu_res = alu_a + alu_b;
      4'b1010: alu_res = alu_a - alu_b;
      default: alu_res = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic load(input logic [1:0] addr, input logic [WIDTH-1:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Issues one instruction with out_ready high and checks the response.
  // Optionally drives a direct load on the EXEC writeback edge.
  task automatic issue(input string tag, input logic [3:0] op, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [1:0] sb,
                       input logic [WIDTH-1:0] exp_data, input logic exp_zero,
                       input bit coll, input logic [1:0] caddr, input logic [WIDTH-1:0] cdata);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_dst   = dst;
    in_srca  = sa;
    in_srcb  = sb;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check({tag, "_sel"}, {28'd0, alu_sel}, {28'd0, op});
        if (coll) begin
          wr_en   = 1'b1;
          wr_addr = caddr;
          wr_data = cdata;
        end
      end else begin
        wr_en = 1'b0;
      end
    end while (!out_valid && lat < 10);
    wr_en = 1'b0;
    check({tag, "_lat"}, lat, 32'd2);
    check({tag, "_data"}, {26'd0, out_data}, {26'd0, exp_data});
    check({tag, "_dst"}, {30'd0, out_dst}, {30'd0, dst});
    check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, exp_zero});
    @(negedge clk);
    check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_hold"}, {28'd0, alu_sel}, {28'd0, op});
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    int bad;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_dst    = '0;
    in_srca   = '0;
    in_srcb   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    out_ready = 1'b1;

    // reset state before any clock edge
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_alu_a", {26'd0, alu_a}, 32'd0);
    check("rst_out_data", {26'd0, out_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // basic AND and readback of the written register
    load(2'd0, 6'b000111);
    load(2'd1, 6'b010101);
    issue("and", 4'b0000, 2'd2, 2'd0, 2'd1, 6'b000101, 1'b0, 1'b0, 2'd0, 6'd0);
    issue("rd_r2", 4'b0001, 2'd2, 2'd2, 2'd2, 6'b000101, 1'b0, 1'b0, 2'd0, 6'd0);

    // further ops in sequence
    issue("or", 4'b0001, 2'd3, 2'd0, 2'd1, 6'b010111, 1'b0, 1'b0, 2'd0, 6'd0);
    issue("xor", 4'b0010, 2'd3, 2'd0, 2'd1, 6'b010010, 1'b0, 1'b0, 2'd0, 6'd0);
    issue("not", 4'b0011, 2'd3, 2'd0, 2'd1, 6'b111000, 1'b0, 1'b0, 2'd0, 6'd0);
    issue("add", 4'b0110, 2'd3, 2'd0, 2'd0, 6'b001110, 1'b0, 1'b0, 2'd0, 6'd0);

    // codes above 1001 go through untouched
    issue("sub", 4'b1010, 2'd3, 2'd1, 2'd0, 6'b001110, 1'b0, 1'b0, 2'd0, 6'd0);
    issue("op_f", 4'b1111, 2'd3, 2'd1, 2'd0, 6'b000000, 1'b1, 1'b0, 2'd0, 6'd0);

    // zero result
    issue("xor0", 4'b0010, 2'd3, 2'd0, 2'd0, 6'b000000, 1'b1, 1'b0, 2'd0, 6'd0);

    // writeback beats a same-edge load to r2; a load to r3 on the same edge lands
    issue("coll", 4'b0000, 2'd2, 2'd0, 2'd1, 6'b000101, 1'b0, 1'b1, 2'd2, 6'b111111);
    issue("rd_c2", 4'b0001, 2'd2, 2'd2, 2'd2, 6'b000101, 1'b0, 1'b0, 2'd0, 6'd0);
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 6'b101010;
    issue("coll3", 4'b0000, 2'd2, 2'd0, 2'd1, 6'b000101, 1'b0, 1'b0, 2'd0, 6'd0);
    issue("rd_c3", 4'b0001, 2'd3, 2'd3, 2'd3, 6'b101010, 1'b0, 1'b0, 2'd0, 6'd0);

    // backpressure: out_ready low for 5 cycles in RESP
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'b0001; in_dst = 2'd2; in_srca = 2'd0; in_srcb = 2'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid0", {31'd0, out_valid}, 32'd1);
    check("bp_data0", {26'd0, out_data}, {26'd0, 6'b010111});
    held = out_data;
    bad = 0;
    in_valid = 1'b1; in_op = 4'b0000; in_dst = 2'd1; in_srca = 2'd0; in_srcb = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid || out_data !== held || in_ready || out_dst !== 2'd2) bad++;
    end
    check("bp_stable", bad, 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid1", {31'd0, out_valid}, 32'd0);
    check("bp_idle", {31'd0, in_ready}, 32'd1);
    // the ignored in_valid must not have overwritten r1
    issue("rd_r1", 4'b0001, 2'd1, 2'd1, 2'd1, 6'b010101, 1'b0, 1'b0, 2'd0, 6'd0);

    // reset during EXEC
    in_valid = 1'b1; in_op = 4'b0110; in_dst = 2'd3; in_srca = 2'd0; in_srcb = 2'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_ready", {31'd0, in_ready}, 32'd0);
    check("mr_alu_a", {26'd0, alu_a}, 32'd0);
    check("mr_alu_b", {26'd0, alu_b}, 32'd0);
    check("mr_sel", {28'd0, alu_sel}, 32'd0);
    check("mr_data", {26'd0, out_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mr_rel_ready", {31'd0, in_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    check("mr_no_stale", bad, 32'd0);
    issue("rd_r0", 4'b0001, 2'd0, 2'd0, 2'd0, 6'b000000, 1'b1, 1'b0, 2'd0, 6'd0);
    issue("rd_r3", 4'b0001, 2'd3, 2'd3, 2'd3, 6'b000000, 1'b1, 1'b0, 2'd0, 6'd0);

    // acceptance on the first edge after reset release
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_op = 4'b0011; in_dst = 2'd1; in_srca = 2'd0; in_srcb = 2'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("first_acc", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_data", {26'd0, out_data}, {26'd0, 6'b111111});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 6, operand/result width in bits.
REQ-002 SHALL have parameter NREG, default 4, number of operand registers; register index width is 2 bits.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, instruction offered.
REQ-006 SHALL have port in_ready, output, 1, instruction accepted when in_valid and in_ready are both high at a rising edge.
REQ-007 SHALL have ports in_op (input, 4, ALU select code), in_dst (input, 2, destination register), in_srca (input, 2, operand A register) and in_srcb (input, 2, operand B register).
REQ-008 SHALL have ports wr_en (input, 1), wr_addr (input, 2) and wr_data (input, WIDTH), for a direct register load.
REQ-009 SHALL have ports alu_a (output, WIDTH), alu_b (output, WIDTH) and alu_sel (output, 4), which drive the downstream combinational ALU.
REQ-010 SHALL have port alu_res, input, WIDTH, the combinational ALU result.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the result handshake.
REQ-012 SHALL have ports out_data (output, WIDTH, result), out_dst (output, 2, destination index) and out_zero (output, 1, result equals 0).

Function
REQ-013 SHALL implement an FSM with states IDLE, EXEC and RESP.
REQ-014 SHALL drive in_ready high only in state IDLE with rst_n high.
REQ-015 SHALL, on acceptance in IDLE (cycle N), register alu_a=rf[in_srca], alu_b=rf[in_srcb], alu_sel=in_op unmodified and dst=in_dst, then enter EXEC.
REQ-016 SHALL pass codes 1010-1111 to alu_sel unchanged, without flagging an error.
REQ-017 SHALL hold alu_a, alu_b and alu_sel stable from cycle N+1 until the next acceptance.
REQ-018 SHALL, at the end of EXEC (cycle N+1), capture alu_res into out_data, write rf[dst]=alu_res, set out_zero=(alu_res==0), set out_dst=dst, and enter RESP.
REQ-019 SHALL assert out_valid in RESP only, first in cycle N+2.
REQ-020 SHALL hold out_valid, out_data, out_dst and out_zero stable while out_valid is high and out_ready is low.
REQ-021 SHALL, in RESP with out_ready high, return to IDLE next cycle; minimum issue interval is 3 cycles.
REQ-022 SHALL read operands at acceptance from register contents before any same-edge write (read-before-write).
REQ-023 SHALL, when wr_en is high, write wr_data to rf[wr_addr] in any state.
REQ-024 SHALL, on a same-edge collision of wr_en and EXEC writeback to the same register, keep the writeback value; different addresses both write.
REQ-025 SHALL allow srca=srcb=dst aliasing with no special handling.
REQ-026 SHALL ignore in_valid outside IDLE.
REQ-027 SHALL treat all data as unsigned WIDTH-bit values; no carry or overflow is produced.

Reset
REQ-028 SHALL, while rst_n is low, force state=IDLE, all rf entries=0, alu_a=0, alu_b=0, alu_sel=0, out_data=0, out_dst=0, out_zero=0, out_valid=0 and in_ready=0, independent of clk.
REQ-029 SHALL, when rst_n is asserted mid-operation (EXEC or RESP), abandon the instruction with no writeback and no out_valid pulse.
REQ-030 SHALL accept an instruction on the first rising edge after rst_n deasserts.

Verification
REQ-031 SHALL pass a directed test: load r0=000111 and r1=010101, then issue op 0000 (r0,r1 -> r2) -> out_valid exactly 2 cycles after acceptance, out_data=000101, out_dst=2, out_zero=0, r2=000101.
REQ-032 SHALL pass a directed test: issue ops 0001, 0010 and 0011 on r0,r1 -> out_data=010111, 010010 and 111000 in order; then op 0110 on r0 -> 001110.
REQ-033 SHALL pass a directed test: hold out_ready low 5 cycles in RESP -> out_valid and out_data stable, in_ready=0, a new in_valid ignored; raise out_ready -> IDLE next cycle.
REQ-034 SHALL pass a directed test: wr_en to r2 with 111111 on the EXEC writeback edge of an op producing 000101 -> r2=000101.
REQ-035 SHALL pass a directed test: op 0010 with r0 XOR r0 -> out_data=000000, out_zero=1.
REQ-036 SHALL pass a directed test: pull rst_n low during EXEC -> out_valid=0, all registers=0, in_ready=0; after release, in_ready=1 and no stale result is emitted.
